// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for the shared memory/IO bus
// Round-robin between m0 and m1 by default; define ARB_FIXED_PRIO_EN to give m0 absolute priority.
module mem_bus_arbiter #(
   parameter int AW       = 9,
   parameter int DW       = 16,
   parameter int READ_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    m0_cmd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic [1:0]    m1_cmd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data,
   output logic [1:0]    grant,
   output logic          busy
);

   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_WR   = 2'b01;
   localparam logic [1:0] CMD_RD   = 2'b10;

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cmd_q, cmd_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          m0_req, m1_req, pick_m1, bus_on;
`ifndef ARB_FIXED_PRIO_EN
   logic          rr_last_q, rr_last_d;
`endif

   // 2'b11 is treated as no request so it can never reach the bus
   assign m0_req = (m0_cmd == CMD_RD) || (m0_cmd == CMD_WR);
   assign m1_req = (m1_cmd == CMD_RD) || (m1_cmd == CMD_WR);

`ifdef ARB_FIXED_PRIO_EN
   assign pick_m1 = m1_req && !m0_req;
`else
   // rr_last_q=1 means m1 owned the previous transaction
   assign pick_m1 = m1_req && (!m0_req || !rr_last_q);
`endif

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      gnt_d      = gnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
      rr_last_d  = rr_last_q;
`endif
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               gnt_d   = pick_m1 ? 2'b10 : 2'b01;
               cmd_d   = pick_m1 ? m1_cmd : m0_cmd;
               addr_d  = pick_m1 ? m1_addr : m0_addr;
               wdata_d = pick_m1 ? m1_wdata : m0_wdata;
`ifndef ARB_FIXED_PRIO_EN
               rr_last_d = pick_m1;
`endif
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (cmd_q == CMD_RD) begin
               cnt_d   = 3'(READ_LAT);
               state_d = RDWAIT;
            end else begin
               state_d = DONE;
            end
         end
         RDWAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               if (gnt_q[1]) m1_rdata_d = read_data;
               else          m0_rdata_d = read_data;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cmd_q      <= CMD_NONE;
         gnt_q      <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= 3'd0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_last_q  <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         gnt_q      <= gnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
`ifndef ARB_FIXED_PRIO_EN
         rr_last_q  <= rr_last_d;
`endif
      end
   end

   // Bus is decoded from state so reset clears it without waiting for a clock
   assign bus_on     = (state_q == ACCESS) || (state_q == RDWAIT);
   assign mem_cmd    = bus_on ? cmd_q : CMD_NONE;
   assign mem_addr   = bus_on ? addr_q : '0;
   assign write_data = bus_on ? wdata_q : '0;
   assign busy       = (state_q != IDLE);
   assign grant      = busy ? gnt_q : 2'b00;
   assign m0_ack     = (state_q == DONE) && gnt_q[0];
   assign m1_ack     = (state_q == DONE) && gnt_q[1];
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
// Model memory and per-master expected responses are queued at issue time and checked on ack.
module tb_mem_bus_arbiter;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam int READ_LAT = 1;

   typedef struct {
      logic [1:0]    cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [1:0]    m0_cmd = 2'b00, m1_cmd = 2'b00;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_ack, m1_ack, busy;
   logic [DW-1:0] m0_rdata, m1_rdata, write_data, read_data;
   logic [1:0]    mem_cmd, grant;
   logic [AW-1:0] mem_addr;
   logic [7:0]    sw = 8'h00;

   int checks = 0;
   int failures = 0;
   int bus_cnt = 0;
   int rd_cyc = 0;

   txn_t          q0[$];
   txn_t          q1[$];
   int            gnt_log[$];
   logic [DW-1:0] ram [512];
   logic [DW-1:0] mdl [512];
   logic [DW-1:0] last_rd [2];

   mem_bus_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
      .clk(clk), .reset(reset),
      .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
      .read_data(read_data), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   // Bus environment: RAM commits at the edge ending a write cycle; read data only
   // becomes valid once MREAD has been held for READ_LAT cycles after ACCESS.
   always @(posedge clk) begin
      if (mem_cmd == 2'b01) ram[mem_addr] <= write_data;
      rd_cyc <= (mem_cmd == 2'b10) ? rd_cyc + 1 : 0;
   end
   assign read_data = (mem_cmd == 2'b10 && rd_cyc >= READ_LAT) ?
                      ((mem_addr == 9'h140) ? {8'h00, sw} : ram[mem_addr]) : 16'hDEAD;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] act);
      checks++;
      failures++;
      $display("FAIL %s actual=%h", name, act);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      txn_t t;
      if (!reset) begin
         bus_cnt = 0;
      end else begin
         if (mem_cmd != 2'b00) begin
            bus_cnt++;
            if (grant == 2'b01 && q0.size() > 0) begin
               chk("bus_cmd_m0", 32'(mem_cmd), 32'(q0[0].cmd));
               chk("bus_addr_m0", 32'(mem_addr), 32'(q0[0].addr));
               if (q0[0].cmd == 2'b01) chk("bus_wdata_m0", 32'(write_data), 32'(q0[0].wd));
            end else if (grant == 2'b10 && q1.size() > 0) begin
               chk("bus_cmd_m1", 32'(mem_cmd), 32'(q1[0].cmd));
               chk("bus_addr_m1", 32'(mem_addr), 32'(q1[0].addr));
               if (q1[0].cmd == 2'b01) chk("bus_wdata_m1", 32'(write_data), 32'(q1[0].wd));
            end else begin
               flag("bus_owner_grant", 32'(grant));
            end
         end
         if (m0_ack) begin
            if (q0.size() == 0) flag("m0_unexpected_ack", 32'(grant));
            else begin
               t = q0.pop_front();
               chk("m0_rdata", 32'(m0_rdata), 32'(t.rd));
               chk("m0_ack_grant", 32'(grant), 32'd1);
               chk("m0_bus_cycles", 32'(bus_cnt), (t.cmd == 2'b10) ? 32'(1 + READ_LAT) : 32'd1);
               gnt_log.push_back(0);
            end
            bus_cnt = 0;
         end
         if (m1_ack) begin
            if (q1.size() == 0) flag("m1_unexpected_ack", 32'(grant));
            else begin
               t = q1.pop_front();
               chk("m1_rdata", 32'(m1_rdata), 32'(t.rd));
               chk("m1_ack_grant", 32'(grant), 32'd2);
               chk("m1_bus_cycles", 32'(bus_cnt), (t.cmd == 2'b10) ? 32'(1 + READ_LAT) : 32'd1);
               gnt_log.push_back(1);
            end
            bus_cnt = 0;
         end
      end
   end

   task automatic drive(input int m, input logic [1:0] cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
      if (m == 0) begin m0_cmd = cmd; m0_addr = addr; m0_wdata = wd; end
      else        begin m1_cmd = cmd; m1_addr = addr; m1_wdata = wd; end
   endtask

   // Called at posedge+1; returns at posedge+1 after the ack cycle has ended.
   task automatic do_txn(input int m, input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output int lat);
      txn_t t;
      bit got;
      t.cmd = cmd; t.addr = addr; t.wd = wd;
      if (cmd == 2'b01) begin
         mdl[addr] = wd;
         t.rd = last_rd[m];
      end else begin
         t.rd = (addr == 9'h140) ? {8'h00, sw} : mdl[addr];
         last_rd[m] = t.rd;
      end
      if (m == 0) q0.push_back(t); else q1.push_back(t);
      drive(m, cmd, addr, wd);
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         lat++;
         if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
      end
      if (!got) begin
         flag((m == 0) ? "m0_ack_timeout" : "m1_ack_timeout", 32'(lat));
         if (m == 0) q0.delete(); else q1.delete();
      end
      @(posedge clk); #1;
      drive(m, 2'b00, '0, '0);
   endtask

   task automatic pulse_reset();
      drive(0, 2'b00, '0, '0);
      drive(1, 2'b00, '0, '0);
      reset = 1'b0;
      q0.delete(); q1.delete();
      last_rd[0] = '0; last_rd[1] = '0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic rand_master(input int m, input int n);
      int lat;
      int gap;
      logic [1:0] cmd;
      logic [AW-1:0] addr;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            drive(m, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 9'(k), 16'(g));
            @(posedge clk); #1;
         end
         cmd = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
         if (m == 0) addr = 9'($urandom_range(0, 255));
         else if (cmd == 2'b10 && $urandom_range(0, 3) == 0) addr = 9'h140;
         else addr = 9'($urandom_range(256, 319));
         do_txn(m, cmd, addr, 16'($urandom), lat);
      end
   endtask

   initial begin
      int lat;
      int l0, l1;
      bit bad;
      for (int i = 0; i < 512; i++) begin ram[i] = '0; mdl[i] = '0; end
      last_rd[0] = '0; last_rd[1] = '0;

      #3;
      chk("rst_mem_cmd", 32'(mem_cmd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_write_data", 32'(write_data), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      do_txn(0, 2'b01, 9'h005, 16'hBEEF, lat);
      chk("wr_latency", 32'(lat), 32'd3);
      chk("ram5", 32'(ram[5]), 32'hBEEF);

      do_txn(0, 2'b10, 9'h005, 16'h0000, lat);
      chk("rd_latency", 32'(lat), 32'(3 + READ_LAT));
      chk("m1_rdata_untouched", 32'(m1_rdata), 32'd0);

      sw = 8'h5A;
      do_txn(1, 2'b10, 9'h140, 16'h0000, lat);
      chk("sw_latency", 32'(lat), 32'(3 + READ_LAT));
      chk("m1_sw_rdata", 32'(m1_rdata), 32'h005A);

      bad = 1'b0;
      drive(1, 2'b11, 9'h033, 16'h1234);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || mem_cmd !== 2'b00) bad = 1'b1;
      end
      chk("cmd11_ignored", 32'(bad), 32'd0);
      @(posedge clk); #1;
      drive(1, 2'b00, '0, '0);

      // Abort a read in RDWAIT with reset
      q0.push_back('{cmd: 2'b10, addr: 9'h005, wd: 16'h0, rd: 16'hBEEF});
      drive(0, 2'b10, 9'h005, 16'h0);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("abort_state_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_mem_cmd", 32'(mem_cmd), 32'd0);
      chk("abort_grant", 32'(grant), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_m0_rdata", 32'(m0_rdata), 32'd0);
      drive(0, 2'b00, '0, '0);
      q0.delete(); q1.delete();
      last_rd[0] = '0; last_rd[1] = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m0_ack !== 1'b0) bad = 1'b1;
      end
      chk("abort_no_ack", 32'(bad), 32'd0);
      @(posedge clk); #1;

      // Continuous contention from reset
      pulse_reset();
      gnt_log.delete();
      fork
         for (int i = 0; i < 4; i++) do_txn(0, 2'b01, 9'(16 + i), 16'(16'hA000 + i), l0);
         for (int i = 0; i < 4; i++) do_txn(1, 2'b01, 9'(272 + i), 16'(16'hB000 + i), l1);
      join
      chk("contend_count", 32'(gnt_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
         chk($sformatf("contend_owner_%0d", i), 32'(gnt_log[i]), (i < 4) ? 32'd0 : 32'd1);
`else
         chk($sformatf("contend_owner_%0d", i), 32'(gnt_log[i]), 32'(i % 2));
`endif
      end

      // Randomized concurrent traffic
      for (int r = 0; r < 3; r++) begin
         sw = 8'($urandom);
         fork
            rand_master(0, 12);
            rand_master(1, 12);
         join
      end
      repeat (3) @(posedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 9-bit-address memory/IO bus (RAM, switch port, LED register) between two masters.
- m0 is the CPU; m1 is a secondary master (debug loader or DMA).
- Serialises transactions, drives mem_cmd/mem_addr/write_data onto the shared bus, and captures read_data.
- Returns per-master read data and a one-cycle ack.

Parameters:
- AW, 9, bus address width.
- DW, 16, data width.
- READ_LAT, 1, RDWAIT cycles before read_data is captured; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- m0_cmd  in  2  m0 request: 2'b10 read, 2'b01 write, 2'b00 or 2'b11 none.
- m0_addr  in  AW  m0 address.
- m0_wdata  in  DW  m0 write data.
- m0_ack  out  1  one-cycle transaction-complete pulse.
- m0_rdata  out  DW  m0 read result.
- m1_cmd, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0 ports, for m1.
- mem_cmd  out  2  bus command.
- mem_addr  out  AW  bus address.
- write_data  out  DW  bus write data.
- read_data  in  DW  bus read data, from the tri-state drivers.
- grant  out  2  one-hot owner of the current transaction; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async), all values forced immediately:
  - state=IDLE
  - mem_cmd=00, mem_addr=0, write_data=0
  - grant=00, busy=0
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0
  - rr_last=1, so m0 wins the first tie
  - wait counter=0
- Reset asserted mid-transaction aborts it; no ack is issued for it.
- Valid request: cmd is 2'b10 or 2'b01. 2'b11 is ignored.
- Master rule: hold cmd/addr/wdata stable from request until the cycle its ack is high; a new cmd may be presented on the edge ending the ack cycle.
- States:
  - IDLE:
    - Bus driven to 00.
    - If exactly one master has a valid request, grant it.
    - If both do, grant the master that is not rr_last.
    - On grant: latch that master's cmd/addr/wdata into internal regs, update rr_last, go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS:
    - Drive the latched cmd/addr/wdata on the bus for exactly one cycle; a write commits in the RAM/LED register at the edge ending this cycle.
    - Write: go to DONE.
    - Read: load wait counter=READ_LAT, go to RDWAIT.
  - RDWAIT:
    - Keep driving the same MREAD and address so the tri-state driver stays enabled.
    - Decrement the counter each cycle.
    - In the cycle the counter reads 1, capture read_data into the granted master's rdata at the ending edge, then go to DONE.
  - DONE:
    - Bus driven to 00.
    - Granted master's ack=1 for this one cycle; its rdata is already valid.
    - grant held; go to IDLE.
- Latency from the first request-visible cycle to the ack cycle:
  - write: 3 cycles (IDLE, ACCESS, DONE).
  - read: 3+READ_LAT cycles.
- The non-granted master's rdata holds its value; rdata changes only at that master's own read capture.
- Writes never modify rdata.
- Requests arriving during a transaction are not lost; they are evaluated at the next IDLE.
- Back-to-back requests from both masters alternate strictly: m0, m1, m0, ...
- An empty IDLE cycle always separates transactions; there is no bus pipelining.
- Inputs are sampled only in IDLE. Changes to cmd/addr/wdata after grant do not affect the bus.
- mem_cmd never carries 2'b11.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined:
  - m0 always wins simultaneous requests.
  - rr_last is not implemented.
  - m1 is served only in IDLE cycles where m0 has no valid request.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset at power-up, then m0_cmd=01, addr=9'h005, wdata=16'hBEEF:
  - mem_cmd=01 with mem_addr=005 and write_data=BEEF for exactly one cycle.
  - m0_ack pulses 2 cycles after grant.
  - RAM[5]=BEEF.
- m0_cmd=10, addr=9'h005, READ_LAT=1:
  - mem_cmd=10 for 2 cycles.
  - m0_ack in cycle 4 with m0_rdata=BEEF.
  - m1_rdata stays 0.
- m1 reads the switch port (addr 9'h140, SW=8'h5A): m1_rdata=16'h005A on m1_ack.
- m0 and m1 both request writes continuously from reset:
  - grant sequence m0, m1, m0, m1.
  - Each ack occurs exactly once per transaction.
  - With ARB_FIXED_PRIO_EN defined: only m0 is granted while m0 keeps requesting.
- m0 read in RDWAIT, then reset pulled low for 1 cycle:
  - Immediately: mem_cmd=00, grant=00, busy=0.
  - No m0_ack.
  - m0_rdata=0.
- m1_cmd=11 with m0 idle: arbiter stays in IDLE, busy=0, mem_cmd=00 throughout.
